// File: rtl/pc_unit_if.sv
// rtl/pc_unit_if.sv - request/response bundle between the pipeline front end and pc_unit
interface pc_unit_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic             halt;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_base;
  logic             jalr_en;
  logic [WIDTH-1:0] jalr_base;
  logic [WIDTH-1:0] imm_op;
  logic             trap;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus;
  logic             fetch_valid;
  logic             flush;
  logic             misalign;

  modport master (
    output stall, halt, branch_taken, branch_base, jalr_en, jalr_base, imm_op, trap,
    input  pc, pc_plus, fetch_valid, flush, misalign
  );

  modport slave (
    input  stall, halt, branch_taken, branch_base, jalr_en, jalr_base, imm_op, trap,
    output pc, pc_plus, fetch_valid, flush, misalign
  );
endinterface

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with prioritised redirects, deferred redirect under stall and halt FSM
// Optional target alignment check enabled by defining PC_MISALIGN_CHECK_EN.
module pc_unit #(
  parameter int          WIDTH        = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0004,
  parameter int          INSTR_BYTES  = 4
) (
  input  logic      clk,
  input  logic      rst,
  pc_unit_if.slave  bus
);
  localparam logic [WIDTH-1:0] RST_PC  = WIDTH'(RESET_VECTOR);
  localparam logic [WIDTH-1:0] TRAP_PC = WIDTH'(TRAP_VECTOR);
  localparam logic [WIDTH-1:0] STEP    = WIDTH'(INSTR_BYTES);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic [WIDTH-1:0] pc_plus;
  logic [WIDTH-1:0] br_tgt, jalr_sum, jalr_tgt, raw_target, target;
  logic             redirect, bad_align, fetch_valid;

  assign pc_plus  = pc_q + STEP;
  assign br_tgt   = bus.branch_base + bus.imm_op;
  assign jalr_sum = bus.jalr_base + bus.imm_op;
  assign jalr_tgt = {jalr_sum[WIDTH-1:1], 1'b0};
  assign redirect = bus.trap | bus.jalr_en | bus.branch_taken;

  // Priority within the cycle: trap, then JALR, then branch.
  assign raw_target = bus.trap    ? TRAP_PC  :
                      bus.jalr_en ? jalr_tgt : br_tgt;

`ifdef PC_MISALIGN_CHECK_EN
  // JALR already has bit0 cleared, so a two-bit test covers both kinds.
  assign bad_align = redirect && !bus.trap && (raw_target[1:0] != 2'b00);
  assign target    = bad_align ? TRAP_PC : raw_target;
`else
  assign bad_align = 1'b0;
  assign target    = raw_target;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    pend_v_d    = pend_v_q;
    fetch_valid = 1'b0;
    case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
        if (redirect) pc_d = target;
      end
      S_RUN: begin
        fetch_valid = 1'b1;
        if (redirect) begin
          if (bus.stall) begin
            pend_d   = target;
            pend_v_d = 1'b1;
          end else begin
            pc_d     = target;
            pend_v_d = 1'b0;
          end
        end else if (bus.halt) begin
          state_d = S_HALT;
        end else if (!bus.stall) begin
          pc_d     = pend_v_q ? pend_q : pc_plus;
          pend_v_d = 1'b0;
        end
      end
      S_HALT: begin
        if (redirect) begin
          pc_d     = target;
          pend_v_d = 1'b0;
          state_d  = S_RUN;
        end else if (!bus.halt) begin
          state_d  = S_RUN;
          if (pend_v_q) pc_d = pend_q;
          pend_v_d = 1'b0;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_BOOT;
      pc_q     <= RST_PC;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pc_plus     = pc_plus;
  assign bus.fetch_valid = fetch_valid;
  assign bus.flush       = redirect & ~rst;
  assign bus.misalign    = bad_align & ~rst;
endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed self-checking bench for pc_unit (32-bit and 8-bit wrap instances)
module tb_pc_unit;
  logic clk;
  logic rst;
  int   n_asserts = 0;
  int   n_fail    = 0;

  pc_unit_if #(.WIDTH(32)) b32 ();
  pc_unit_if #(.WIDTH(8))  b8 ();

  pc_unit #(.WIDTH(32), .RESET_VECTOR(32'h100), .TRAP_VECTOR(32'h4), .INSTR_BYTES(4))
    u_dut32 (.clk(clk), .rst(rst), .bus(b32.slave));

  pc_unit #(.WIDTH(8), .RESET_VECTOR(32'hF8), .TRAP_VECTOR(32'h4), .INSTR_BYTES(4))
    u_dut8 (.clk(clk), .rst(rst), .bus(b8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    b32.branch_taken = 1'b0;
    b32.jalr_en      = 1'b0;
    b32.trap         = 1'b0;
    b32.branch_base  = '0;
    b32.jalr_base    = '0;
    b32.imm_op       = '0;
  endtask

  task automatic branch_to(input logic [31:0] base, input logic [31:0] imm);
    b32.branch_taken = 1'b1;
    b32.branch_base  = base;
    b32.imm_op       = imm;
  endtask

  initial begin
    rst = 1'b1;
    clear_req();
    b32.stall = 1'b0; b32.halt = 1'b0;
    b8.stall = 1'b0; b8.halt = 1'b0; b8.branch_taken = 1'b0; b8.jalr_en = 1'b0;
    b8.trap = 1'b0; b8.branch_base = '0; b8.jalr_base = '0; b8.imm_op = '0;

    step(); step();
    check("reset_pc", b32.pc, 32'h100);
    check("reset_fv", {31'b0, b32.fetch_valid}, 32'h0);
    branch_to(32'h0, 32'h40);
    #1;
    check("reset_flush_masked", {31'b0, b32.flush}, 32'h0);
    check("reset_misalign", {31'b0, b32.misalign}, 32'h0);
    clear_req();

    rst = 1'b0;
    #1;
    check("boot_fv", {31'b0, b32.fetch_valid}, 32'h0);
    check("boot_pc", b32.pc, 32'h100);
    step();
    check("run_pc0", b32.pc, 32'h100);
    check("run_fv", {31'b0, b32.fetch_valid}, 32'h1);
    check("w8_pc0", {24'b0, b8.pc}, 32'hF8);
    step();
    check("run_pc1", b32.pc, 32'h104);
    check("w8_pc_plus_wrap", {24'b0, b8.pc_plus}, 32'h00);
    step();
    check("run_pc2", b32.pc, 32'h108);
    check("run_pc_plus", b32.pc_plus, 32'h10C);
    check("w8_wrap", {24'b0, b8.pc}, 32'h00);

    // priority: JALR beats branch, trap beats both
    branch_to(32'h0, 32'h20);
    #1;
    check("br_flush", {31'b0, b32.flush}, 32'h1);
    step();
    check("br_pc", b32.pc, 32'h20);
    branch_to(32'h20, 32'h40);
    b32.jalr_en = 1'b1; b32.jalr_base = 32'h300;
    #1;
    check("prio_flush", {31'b0, b32.flush}, 32'h1);
    step();
    check("prio_jalr", b32.pc, 32'h340);
    b32.trap = 1'b1;
    step();
    check("prio_trap", b32.pc, 32'h4);
    clear_req();
    b32.jalr_en = 1'b1; b32.jalr_base = 32'h301;
    step();
    check("jalr_bit0", b32.pc, 32'h300);
    clear_req();
    #1;
    check("no_flush", {31'b0, b32.flush}, 32'h0);

    // stalled redirect is deferred
    b32.stall = 1'b1;
    branch_to(32'h40, 32'h40);
    step();
    check("stall_pc0", b32.pc, 32'h300);
    clear_req();
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold", b32.pc, 32'h300);
    end
    b32.stall = 1'b0;
    step();
    check("stall_apply", b32.pc, 32'h80);
    step();
    check("stall_seq", b32.pc, 32'h84);

    // newer redirect during stall overwrites pending
    b32.stall = 1'b1;
    branch_to(32'h80, 32'h10);
    step();
    clear_req();
    b32.jalr_en = 1'b1; b32.jalr_base = 32'hA0;
    step();
    clear_req();
    b32.stall = 1'b0;
    step();
    check("pend_overwrite", b32.pc, 32'hA0);

    // halt / resume
    branch_to(32'h0, 32'h40);
    step();
    clear_req();
    b32.halt = 1'b1;
    #1;
    check("halt_req_fv", {31'b0, b32.fetch_valid}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("halt_pc", b32.pc, 32'h40);
      check("halt_fv", {31'b0, b32.fetch_valid}, 32'h0);
    end
    b32.halt = 1'b0;
    step();
    check("resume_fv", {31'b0, b32.fetch_valid}, 32'h1);
    check("resume_pc", b32.pc, 32'h40);
    step();
    check("resume_seq", b32.pc, 32'h44);

    // pending survives halt
    b32.stall = 1'b1;
    branch_to(32'h0, 32'h60);
    step();
    clear_req();
    b32.halt = 1'b1;
    step();
    check("halt_pend_pc", b32.pc, 32'h44);
    b32.halt = 1'b0; b32.stall = 1'b0;
    step();
    check("halt_pend_apply", b32.pc, 32'h60);
    step();
    check("halt_pend_seq", b32.pc, 32'h64);

    // redirect while halted
    b32.halt = 1'b1;
    step();
    check("halt2_fv", {31'b0, b32.fetch_valid}, 32'h0);
    b32.jalr_en = 1'b1; b32.jalr_base = 32'h200;
    step();
    check("halt_jalr_pc", b32.pc, 32'h200);
    check("halt_jalr_fv", {31'b0, b32.fetch_valid}, 32'h1);
    clear_req();
    b32.halt = 1'b0;
    step();
    check("halt_jalr_seq", b32.pc, 32'h204);

    // async reset with a pending redirect
    b32.stall = 1'b1;
    branch_to(32'h40, 32'h40);
    step();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_pc", b32.pc, 32'h100);
    check("async_rst_fv", {31'b0, b32.fetch_valid}, 32'h0);
    #1;
    rst = 1'b0;
    clear_req();
    b32.stall = 1'b0;
    step();
    check("post_rst_pc0", b32.pc, 32'h100);
    step();
    check("post_rst_pc1", b32.pc, 32'h104);

    // alignment check
    branch_to(32'h80, 32'h2);
    #1;
`ifdef PC_MISALIGN_CHECK_EN
    check("misalign_flag", {31'b0, b32.misalign}, 32'h1);
    step();
    check("misalign_pc", b32.pc, 32'h4);
`else
    check("misalign_flag", {31'b0, b32.misalign}, 32'h0);
    step();
    check("misalign_pc", b32.pc, 32'h82);
`endif
    clear_req();
    #1;
    check("misalign_clear", {31'b0, b32.misalign}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit; successor to the single-cycle PC/adder/mux/register block.
- Adds reset vector, stall with deferred redirect, prioritised redirect sources (trap, JALR, branch), halt/resume FSM and a fetch-valid qualifier.
- Sits at the front of the pipelined core and drives instruction-memory address and fetch-valid.

Parameters:
- WIDTH, 32, PC/address width in bits (>= 8).
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (truncated to WIDTH).
- TRAP_VECTOR, 32'h0000_0004, PC loaded on trap redirect (truncated to WIDTH).
- INSTR_BYTES, 4, sequential increment in bytes.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC (fetch back-pressure / hazard).
- halt  in  1  request halt; PC freezes, fetch stops.
- branch_taken  in  1  branch redirect request.
- branch_base  in  WIDTH  PC of the branching instruction.
- jalr_en  in  1  register-indirect jump request.
- jalr_base  in  WIDTH  rs1 value for JALR.
- imm_op  in  WIDTH  sign-extended immediate, shared by branch/JALR.
- trap  in  1  exception redirect request.
- pc  out  WIDTH  current fetch address.
- pc_plus  out  WIDTH  pc + INSTR_BYTES (combinational, wraps mod 2^WIDTH).
- fetch_valid  out  1  pc is a valid fetch request this cycle.
- flush  out  1  younger in-flight instructions must be killed.
- misalign  out  1  misaligned target detected (optional feature only).

Behaviour:
- Reset (async, any time, including mid-stall or with a pending redirect): pc=RESET_VECTOR, FSM=BOOT, pending cleared, fetch_valid=0. flush and misalign are 0 while rst=1.
- Targets:
  - branch target = branch_base + imm_op.
  - JALR target = (jalr_base + imm_op) with bit0 cleared.
  - All sums are modulo 2^WIDTH; overflow is dropped.
- Redirect priority, evaluated in the same cycle: trap > jalr_en > branch_taken. Lower-priority requests in that cycle are discarded.
- flush = 1 combinationally in any cycle where a redirect is accepted, i.e. any of trap/jalr_en/branch_taken=1 and rst=0.
- FSM states:
  - BOOT: fetch_valid=0, pc holds. Moves to RUN on the next clock after rst deasserts. A redirect in BOOT is applied and moves to RUN.
  - RUN: fetch_valid=1.
    - Redirect with stall=0: pc <= target next edge; pending cleared.
    - Redirect with stall=1: target latched into pending register; pc holds.
    - No redirect, stall=0: pc <= pending target if pending, else pc_plus. pending is cleared.
    - stall=1, no redirect: pc and pending hold.
    - A newer redirect during stall overwrites pending, subject to priority within its own cycle only.
    - halt=1 (and no redirect): -> HALT, pc holds; pending is retained.
  - HALT: fetch_valid=0, pc holds, stall ignored. Any redirect loads its target and returns to RUN; halt is ignored that cycle. Otherwise, halt=0 returns to RUN, applying pending if set.
- Latency: one cycle from redirect or sequential decision to pc update. Redirect-to-new-pc is 1 cycle when unstalled.
- Wrap-around: pc=2^WIDTH-INSTR_BYTES advances to 0.

Optional Feature:
- Macro: PC_MISALIGN_CHECK_EN.
- Defined: an accepted target is checked for alignment. A target with bits [1:0] != 0 (or bit1 != 0 for JALR) causes:
  - misalign=1 for that cycle;
  - pc <= TRAP_VECTOR instead of the target (same stall/pending rules).
  - Trap targets are never checked.
- Undefined: no alignment logic; misalign tied 0; targets used as computed.

Test Plan:
- Reset/boot: rst 1 -> 0 with RESET_VECTOR=0x100 -> pc=0x100, fetch_valid=0 for one cycle, then pc=0x100 valid, 0x104, 0x108 on successive edges.
- Branch priority: at pc=0x20, branch_taken=1, branch_base=0x20, imm_op=0x40, jalr_en=1, jalr_base=0x300, imm_op shared -> flush=1, next pc=0x340 (JALR wins); trap=1 added same cycle -> next pc=TRAP_VECTOR.
- Stalled redirect: stall=1, branch to 0x80 for one cycle, stall held 3 more cycles -> pc frozen throughout; after stall drops, next pc=0x80, then 0x84.
- Halt/resume: halt at pc=0x40 -> fetch_valid=0, pc=0x40 held 5 cycles; halt=0 -> fetch_valid=1, pc advances to 0x44. Separately, jalr_en to 0x200 while halted -> pc=0x200, RUN.
- Wrap and async reset: WIDTH=8, pc=0xFC -> next 0x00. rst pulsed mid-cycle with a pending redirect -> pc=RESET_VECTOR immediately, pending discarded.
- PC_MISALIGN_CHECK_EN: branch target 0x82 -> misalign=1, pc=TRAP_VECTOR. Without the macro -> pc=0x82, misalign=0.
